// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready handshake bundle for one pipeline stage (upstream in_*, downstream out_*)
// master: the side that drives in_* and out_ready; slave: the stage itself
interface pipe_stage_skid_if #(
    parameter int DATA_W = 68,
    parameter int CTRL_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with two-entry skid buffer, flush and bubble ctrl kill
// ports: clk; reset (sync, active-high); flush (drops held entries and same-cycle input);
//        bus (slave) carries in_valid/in_ready/in_data/in_ctrl and out_valid/out_ready/out_data/out_ctrl;
//        occupancy = held entries 0..2; stall_cnt = saturating count of out_valid && !out_ready cycles
module pipe_stage_skid #(
    parameter int DATA_W = 68,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_skid_if.slave bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              acc, pop, load_main, load_skid, shift;

    always_ff @(posedge clk)
        if (reset) state <= EMPTY;
        else       state <= state_nxt;

    always_comb begin
        acc       = bus.in_valid && bus.in_ready;
        pop       = bus.out_valid && bus.out_ready;
        state_nxt = flush ? EMPTY :
                    state == EMPTY ? (acc ? ONE : EMPTY) :
                    state == ONE   ? (acc && !pop ? TWO : (!acc && pop ? EMPTY : ONE)) :
                                     (pop ? ONE : TWO);
        // a new entry goes straight to main when main is free or being popped
        load_main = acc && (state == EMPTY || (state == ONE && pop));
        load_skid = acc && state == ONE && !pop;
        shift     = pop && state == TWO;
    end

    always_comb begin
        bus.in_ready  = state != TWO;
        bus.out_valid = state != EMPTY;
        bus.out_data  = main_data;
        bus.out_ctrl  = bus.out_valid ? main_ctrl : '0;
        occupancy     = state;
    end

    // flush clears only the control fields; data is left alone so the bus stays quiet
    always_ff @(posedge clk)
        if (reset) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main) begin
                main_data <= bus.in_data;
                main_ctrl <= bus.in_ctrl;
            end else if (shift) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= bus.in_data;
                skid_ctrl <= bus.in_ctrl;
            end
        end

    always_ff @(posedge clk)
        if (reset)                                                   stall_cnt <= '0;
        else if (bus.out_valid && !bus.out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
endmodule
